// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard unit: in-flight entry record,
// register-file select code and the forward-select width helper.
package pipe_pkg;

  // Entry rd field is sized for the widest supported register address;
  // narrower AW values are zero-extended into it.
  localparam int MAX_AW = 16;

  localparam int FWD_RF = 0;

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic              load;
    logic [MAX_AW-1:0] rd;
  } entry_t;

  function automatic int selWidth(input int stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_match.sv
// Youngest-match priority encoder: finds the lowest-index valid writer of
// one source register among the in-flight entries.
module pipe_match
  import pipe_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int AW = 5,
  localparam int SW = selWidth(STAGES)
) (
  input  entry_t [STAGES-1:0] entries_i,
  input  logic [AW-1:0]       rs_i,
  input  logic                used_i,
  output logic                hit_o,
  output logic [SW-1:0]       idx_o,
  output logic                load_o
);

  logic [MAX_AW-1:0] rsExt;

  assign rsExt = MAX_AW'(rs_i);

  // Scan oldest to youngest so the youngest matching entry overwrites the rest.
  always_comb begin
    hit_o  = 1'b0;
    idx_o  = '0;
    load_o = 1'b0;
    if (used_i && (rs_i != '0)) begin
      for (int k = STAGES - 1; k >= 0; k--) begin
        if (entries_i[k].valid && entries_i[k].wr && (entries_i[k].rd == rsExt)) begin
          hit_o  = 1'b1;
          idx_o  = SW'(k);
          load_o = entries_i[k].load;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// In-order pipeline hazard unit: tracks in-flight writers, forwards or stalls
// on RAW hazards, flushes on redirect. Forwarding is enabled by PIPE_HAZARD_FWD_EN.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int AW = 5,
  parameter int LOAD_STAGE = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic                        id_valid_i,
  input  logic [AW-1:0]               id_rd_i,
  input  logic                        id_reg_write_i,
  input  logic                        id_load_i,
  input  logic [AW-1:0]               id_rs1_i,
  input  logic [AW-1:0]               id_rs2_i,
  input  logic                        id_rs1_used_i,
  input  logic                        id_rs2_used_i,
  input  logic                        ex_redirect_i,
  input  logic                        ext_stall_i,
  output logic                        stall_o,
  output logic                        flush_o,
  output logic [selWidth(STAGES)-1:0] fwd1_sel_o,
  output logic [selWidth(STAGES)-1:0] fwd2_sel_o,
  output logic                        busy_o
);

  localparam int SW = selWidth(STAGES);
  localparam logic [SW-1:0] LOAD_IDX = SW'(LOAD_STAGE);
  localparam logic [SW-1:0] LAST_IDX = SW'(STAGES - 1);

  entry_t [STAGES-1:0] entries_q;
  entry_t [STAGES-1:0] entries_d;
  entry_t              idEntry;

  logic          hit1;
  logic          hit2;
  logic          load1;
  logic          load2;
  logic [SW-1:0] idx1;
  logic [SW-1:0] idx2;
  logic          hazard;
  logic          flush;
  logic          stall;
  logic          bubble;

  pipe_match #(
    .STAGES(STAGES),
    .AW    (AW)
  ) u_match1 (
    .entries_i(entries_q),
    .rs_i     (id_rs1_i),
    .used_i   (id_rs1_used_i),
    .hit_o    (hit1),
    .idx_o    (idx1),
    .load_o   (load1)
  );

  pipe_match #(
    .STAGES(STAGES),
    .AW    (AW)
  ) u_match2 (
    .entries_i(entries_q),
    .rs_i     (id_rs2_i),
    .used_i   (id_rs2_used_i),
    .hit_o    (hit2),
    .idx_o    (idx2),
    .load_o   (load2)
  );

`ifdef PIPE_HAZARD_FWD_EN
  // Only a load too young to have produced its data forces a stall.
  always_comb begin
    hazard = (hit1 && load1 && (idx1 < LOAD_IDX)) ||
             (hit2 && load2 && (idx2 < LOAD_IDX));
  end

  assign fwd1_sel_o = hit1 ? (idx1 + SW'(1)) : SW'(FWD_RF);
  assign fwd2_sel_o = hit2 ? (idx2 + SW'(1)) : SW'(FWD_RF);
`else
  logic unusedLoads;

  // Without bypass paths every producer must reach the write-through stage.
  always_comb begin
    hazard = (hit1 && (idx1 < LAST_IDX)) ||
             (hit2 && (idx2 < LAST_IDX));
  end

  assign unusedLoads = load1 | load2;
  assign fwd1_sel_o  = SW'(FWD_RF);
  assign fwd2_sel_o  = SW'(FWD_RF);
`endif

  // A redirect kills the decode instruction, so its hazard no longer matters.
  always_comb begin
    flush = ex_redirect_i && !ext_stall_i;
    stall = (hazard && !flush) || ext_stall_i;
  end

  assign stall_o = !rst_i && stall;
  assign flush_o = !rst_i && flush;

  always_comb begin
    busy_o = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      busy_o = busy_o | entries_q[k].valid;
    end
  end

  always_comb begin
    bubble  = !id_valid_i || !start_i || stall || flush;
    idEntry = '0;
    if (!bubble) begin
      idEntry.valid = 1'b1;
      idEntry.wr    = id_reg_write_i;
      idEntry.load  = id_load_i;
      idEntry.rd    = MAX_AW'(id_rd_i);
    end
    entries_d = entries_q;
    if (!ext_stall_i) begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        entries_d[k] = entries_q[k-1];
      end
      entries_d[0] = idEntry;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      entries_q <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit (STAGES=3, LOAD_STAGE=1); expectations
// adapt to whether PIPE_HAZARD_FWD_EN is defined.
module tb_pipe_hazard_unit;

  localparam int S  = 3;
  localparam int AW = 5;
  localparam int LS = 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          id_valid_i;
  logic [AW-1:0] id_rd_i;
  logic          id_reg_write_i;
  logic          id_load_i;
  logic [AW-1:0] id_rs1_i;
  logic [AW-1:0] id_rs2_i;
  logic          id_rs1_used_i;
  logic          id_rs2_used_i;
  logic          ex_redirect_i;
  logic          ext_stall_i;
  logic          stall_o;
  logic          flush_o;
  logic [1:0]    fwd1_sel_o;
  logic [1:0]    fwd2_sel_o;
  logic          busy_o;

  int nCompared = 0;
  int nFailed   = 0;

  // Reference pipeline: one slot per in-flight stage, 0 = youngest.
  int mValid[S] = '{default: 0};
  int mRd[S]    = '{default: 0};
  int mWr[S]    = '{default: 0};
  int mLoad[S]  = '{default: 0};

  pipe_hazard_unit #(
    .STAGES    (S),
    .AW        (AW),
    .LOAD_STAGE(LS)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .id_valid_i    (id_valid_i),
    .id_rd_i       (id_rd_i),
    .id_reg_write_i(id_reg_write_i),
    .id_load_i     (id_load_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .ex_redirect_i (ex_redirect_i),
    .ext_stall_i   (ext_stall_i),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .fwd1_sel_o    (fwd1_sel_o),
    .fwd2_sel_o    (fwd2_sel_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic void youngest(input int rs, input bit used, output int idx, output bit ld);
    idx = -1;
    ld  = 1'b0;
    if (used && rs != 0) begin
      for (int k = 0; k < S; k++) begin
        if (idx < 0 && mValid[k] != 0 && mWr[k] != 0 && mRd[k] == rs) begin
          idx = k;
          ld  = (mLoad[k] != 0);
        end
      end
    end
  endfunction

  function automatic void calc(output int eStall, output int eFlush, output int eF1,
                               output int eF2, output int eBusy);
    int i1;
    int i2;
    bit l1;
    bit l2;
    bit hazard;
    youngest(int'(id_rs1_i), id_rs1_used_i, i1, l1);
    youngest(int'(id_rs2_i), id_rs2_used_i, i2, l2);
    eBusy = 0;
    for (int k = 0; k < S; k++) if (mValid[k] != 0) eBusy = 1;
    eFlush = (ex_redirect_i && !ext_stall_i) ? 1 : 0;
`ifdef PIPE_HAZARD_FWD_EN
    hazard = (i1 >= 0 && l1 && i1 < LS) || (i2 >= 0 && l2 && i2 < LS);
    eF1 = i1 + 1;
    eF2 = i2 + 1;
`else
    hazard = (i1 >= 0 && i1 < S - 1) || (i2 >= 0 && i2 < S - 1);
    eF1 = 0;
    eF2 = 0;
`endif
    eStall = ((hazard && eFlush == 0) || ext_stall_i) ? 1 : 0;
    if (rst_i) begin
      eStall = 0;
      eFlush = 0;
      eF1    = 0;
      eF2    = 0;
      eBusy  = 0;
    end
  endfunction

  // Advance the reference pipeline using the model's own stall/flush decision.
  always @(posedge clk_i or posedge rst_i) begin
    int s, f, a, b, y;
    if (rst_i) begin
      for (int k = 0; k < S; k++) begin
        mValid[k] <= 0;
        mRd[k]    <= 0;
        mWr[k]    <= 0;
        mLoad[k]  <= 0;
      end
    end else if (!ext_stall_i) begin
      calc(s, f, a, b, y);
      for (int k = S - 1; k >= 1; k--) begin
        mValid[k] <= mValid[k-1];
        mRd[k]    <= mRd[k-1];
        mWr[k]    <= mWr[k-1];
        mLoad[k]  <= mLoad[k-1];
      end
      if (id_valid_i && start_i && s == 0 && f == 0) begin
        mValid[0] <= 1;
        mRd[0]    <= int'(id_rd_i);
        mWr[0]    <= int'(id_reg_write_i);
        mLoad[0]  <= int'(id_load_i);
      end else begin
        mValid[0] <= 0;
        mRd[0]    <= 0;
        mWr[0]    <= 0;
        mLoad[0]  <= 0;
      end
    end
  end

  always @(negedge clk_i) begin
    int s, f, a, b, y;
    calc(s, f, a, b, y);
    checkOutput("model_stall", int'(stall_o), s);
    checkOutput("model_flush", int'(flush_o), f);
    checkOutput("model_fwd1", int'(fwd1_sel_o), a);
    checkOutput("model_fwd2", int'(fwd2_sel_o), b);
    checkOutput("model_busy", int'(busy_o), y);
  end

  // Present one decode-stage vector just after a rising edge; return after the falling edge.
  task automatic applyStimulus(input bit v, input int rd, input bit wr, input bit ld,
                               input int rs1, input bit u1, input int rs2, input bit u2,
                               input bit redir, input bit ext);
    @(posedge clk_i);
    #1;
    id_valid_i     = v;
    id_rd_i        = AW'(rd);
    id_reg_write_i = wr;
    id_load_i      = ld;
    id_rs1_i       = AW'(rs1);
    id_rs1_used_i  = u1;
    id_rs2_i       = AW'(rs2);
    id_rs2_used_i  = u2;
    ex_redirect_i  = redir;
    ext_stall_i    = ext;
    @(negedge clk_i);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < S; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_i          = 1'b1;
    start_i        = 1'b1;
    id_valid_i     = 1'b0;
    id_rd_i        = '0;
    id_reg_write_i = 1'b0;
    id_load_i      = 1'b0;
    id_rs1_i       = '0;
    id_rs2_i       = '0;
    id_rs1_used_i  = 1'b0;
    id_rs2_used_i  = 1'b0;
    ex_redirect_i  = 1'b0;
    ext_stall_i    = 1'b0;
    #7;
    checkOutput("rst_stall", int'(stall_o), 0);
    checkOutput("rst_flush", int'(flush_o), 0);
    checkOutput("rst_fwd1", int'(fwd1_sel_o), 0);
    checkOutput("rst_busy", int'(busy_o), 0);
    #5;
    rst_i = 1'b0;

    $display("[TB] ALU RAW chain on x5");
    applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("raw_c1_stall", int'(stall_o), 0);
    applyStimulus(1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
`ifdef PIPE_HAZARD_FWD_EN
    checkOutput("raw_c2_fwd1", int'(fwd1_sel_o), 1);
    checkOutput("raw_c2_stall", int'(stall_o), 0);
`else
    checkOutput("raw_c2_stall", int'(stall_o), 1);
    checkOutput("raw_c2_fwd1", int'(fwd1_sel_o), 0);
`endif
    applyStimulus(1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
`ifdef PIPE_HAZARD_FWD_EN
    checkOutput("raw_c3_fwd1", int'(fwd1_sel_o), 2);
    checkOutput("raw_c3_stall", int'(stall_o), 0);
`else
    checkOutput("raw_c3_stall", int'(stall_o), 1);
`endif
    applyStimulus(1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
`ifdef PIPE_HAZARD_FWD_EN
    checkOutput("raw_c4_fwd1", int'(fwd1_sel_o), 3);
`endif
    checkOutput("raw_c4_stall", int'(stall_o), 0);
    applyStimulus(1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    checkOutput("raw_c5_fwd1", int'(fwd1_sel_o), 0);
    checkOutput("raw_c5_stall", int'(stall_o), 0);
    drain();

    $display("[TB] load-use on x6");
    applyStimulus(1, 6, 1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("lu_c1_stall", int'(stall_o), 0);
    applyStimulus(1, 7, 1, 0, 0, 0, 6, 1, 0, 0);
    checkOutput("lu_c2_stall", int'(stall_o), 1);
    applyStimulus(1, 7, 1, 0, 0, 0, 6, 1, 0, 0);
`ifdef PIPE_HAZARD_FWD_EN
    checkOutput("lu_c3_stall", int'(stall_o), 0);
    checkOutput("lu_c3_fwd2", int'(fwd2_sel_o), 2);
`else
    checkOutput("lu_c3_stall", int'(stall_o), 1);
    applyStimulus(1, 7, 1, 0, 0, 0, 6, 1, 0, 0);
    checkOutput("lu_c4_stall", int'(stall_o), 0);
`endif
    drain();

    $display("[TB] register zero");
    applyStimulus(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    checkOutput("x0_fwd1", int'(fwd1_sel_o), 0);
    checkOutput("x0_fwd2", int'(fwd2_sel_o), 0);
    checkOutput("x0_stall", int'(stall_o), 0);
    drain();

    $display("[TB] redirect over pending load-use");
    applyStimulus(1, 8, 1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 9, 1, 0, 8, 1, 0, 0, 1, 0);
    checkOutput("redir_flush", int'(flush_o), 1);
    checkOutput("redir_stall", int'(stall_o), 0);
    applyStimulus(1, 0, 0, 0, 8, 1, 9, 1, 0, 0);
    checkOutput("redir_killed_fwd2", int'(fwd2_sel_o), 0);
    checkOutput("redir_after_flush", int'(flush_o), 0);
`ifdef PIPE_HAZARD_FWD_EN
    checkOutput("redir_after_fwd1", int'(fwd1_sel_o), 2);
`else
    checkOutput("redir_after_stall", int'(stall_o), 1);
`endif
    drain();

    $display("[TB] three-cycle external stall");
    applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 5, 1, 0, 0, (i == 1), 1);
      checkOutput("ext_stall", int'(stall_o), 1);
      checkOutput("ext_flush", int'(flush_o), 0);
      checkOutput("ext_busy", int'(busy_o), 1);
`ifdef PIPE_HAZARD_FWD_EN
      checkOutput("ext_fwd1", int'(fwd1_sel_o), 2);
`else
      checkOutput("ext_fwd1", int'(fwd1_sel_o), 0);
`endif
    end
    applyStimulus(1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
`ifdef PIPE_HAZARD_FWD_EN
    checkOutput("ext_resume_fwd1", int'(fwd1_sel_o), 2);
    checkOutput("ext_resume_stall", int'(stall_o), 0);
    applyStimulus(1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    checkOutput("ext_resume2_fwd1", int'(fwd1_sel_o), 3);
`else
    checkOutput("ext_resume_stall", int'(stall_o), 1);
    applyStimulus(1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    checkOutput("ext_resume2_stall", int'(stall_o), 0);
`endif
    drain();

    $display("[TB] async reset with full pipeline");
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 3, 1, 1, 1, 0, 0);
    checkOutput("full_busy", int'(busy_o), 1);
`ifdef PIPE_HAZARD_FWD_EN
    checkOutput("full_fwd1", int'(fwd1_sel_o), 1);
    checkOutput("full_fwd2", int'(fwd2_sel_o), 3);
`else
    checkOutput("full_stall", int'(stall_o), 1);
`endif
    #1;
    rst_i         = 1'b1;
    ext_stall_i   = 1'b1;
    ex_redirect_i = 1'b1;
    #1;
    checkOutput("arst_busy", int'(busy_o), 0);
    checkOutput("arst_fwd1", int'(fwd1_sel_o), 0);
    checkOutput("arst_fwd2", int'(fwd2_sel_o), 0);
    checkOutput("arst_stall", int'(stall_o), 0);
    checkOutput("arst_flush", int'(flush_o), 0);
    @(posedge clk_i);
    #2;
    ext_stall_i    = 1'b0;
    ex_redirect_i  = 1'b0;
    id_valid_i     = 1'b1;
    id_rd_i        = AW'(4);
    id_reg_write_i = 1'b1;
    id_load_i      = 1'b0;
    id_rs1_used_i  = 1'b0;
    id_rs2_used_i  = 1'b0;
    rst_i          = 1'b0;
    applyStimulus(1, 0, 0, 0, 4, 1, 0, 0, 0, 0);
`ifdef PIPE_HAZARD_FWD_EN
    checkOutput("post_rst_fwd1", int'(fwd1_sel_o), 1);
`else
    checkOutput("post_rst_stall", int'(stall_o), 1);
`endif
    drain();

    $display("[TB] run enable low inserts bubbles");
    start_i = 1'b0;
    applyStimulus(1, 10, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 10, 1, 0, 0, 0, 0);
    start_i = 1'b1;
    checkOutput("start_fwd1", int'(fwd1_sel_o), 0);
    checkOutput("start_stall", int'(stall_o), 0);
    checkOutput("start_busy", int'(busy_o), 0);

    $display("[TB] mixed traffic against the model");
    for (int i = 0; i < 80; i++) begin
      start_i = ($urandom_range(0, 9) != 0);
      applyStimulus($urandom_range(0, 4) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                    $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 1),
                    $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 5) == 0,
                    $urandom_range(0, 4) == 0);
    end
    start_i = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameter STAGES, default 3, giving tracked in-flight stages after decode (index 0 = EX … STAGES-1 = WB, the register-file write stage).
REQ-002 SHALL have parameter AW, default 5, giving the register-address width.
REQ-003 SHALL have parameter LOAD_STAGE, default 1, giving the lowest stage index from which a load result is forwardable.
REQ-004 SHALL use one clock; reset is asynchronous and active-high; ports are clk_i and rst_i.
REQ-005 SHALL have ports clk_i in 1 (clock) and rst_i in 1 (async active-high reset).
REQ-006 SHALL have port start_i in 1: run enable; when low, bubbles enter.
REQ-007 SHALL have ports id_valid_i in 1, id_rd_i in AW, id_reg_write_i in 1 and id_load_i in 1, describing the decode-stage instruction.
REQ-008 SHALL have ports id_rs1_i in AW, id_rs2_i in AW, id_rs1_used_i in 1 and id_rs2_used_i in 1, giving the decode-stage source operands.
REQ-009 SHALL have port ex_redirect_i in 1: taken branch/jump resolved in stage 0.
REQ-010 SHALL have port ext_stall_i in 1: memory stall that freezes all stages.
REQ-011 SHALL have port stall_o out 1: hold PC and IF/ID, and insert a bubble.
REQ-012 SHALL have port flush_o out 1: kill the IF/ID instruction.
REQ-013 SHALL have ports fwd1_sel_o and fwd2_sel_o out clog2(STAGES+1): 0 = register file, k = result of stage k-1.
REQ-014 SHALL have port busy_o out 1: at least one valid in-flight entry.

Function
REQ-015 SHALL hold STAGES entries {valid, rd, wr, load} as a shift register.
REQ-016 SHALL advance entries when ext_stall_i=0: entry[k+1]<=entry[k]; entry[0]<=decode instruction, or a bubble if id_valid_i=0, start_i=0, stall_o=1 or flush_o=1.
REQ-017 SHALL freeze all entries when ext_stall_i=1.
REQ-018 SHALL match operand rsN only if used, rsN!=0 and a valid entry has wr=1 and rd==rsN; the lowest index (youngest) wins, giving fwdN_sel_o=k+1, otherwise 0.
REQ-019 SHALL never match register 0, whatever rd or wr is.
REQ-020 SHALL raise stall_o (load-use) when either operand's winning entry has load=1 and k<LOAD_STAGE.
REQ-021 SHALL compute stall_o = load-use OR ext_stall_i.
REQ-022 SHALL set flush_o = ex_redirect_i AND NOT ext_stall_i.
REQ-023 SHALL force the load-use term of stall_o to 0 when flush_o=1, since redirect has priority.
REQ-024 SHALL treat ex_redirect_i as held by its source while ext_stall_i=1; no flush occurs during the freeze.
REQ-025 SHALL compute all outputs combinationally from entries and current inputs, adding zero cycles of latency.
REQ-026 SHALL produce a load-use stall lasting exactly LOAD_STAGE-k cycles.

Reset
REQ-027 SHALL invalidate all entries immediately on rst_i=1.
REQ-028 SHALL, on rst_i=1, drive stall_o=0, flush_o=0, fwd*_sel_o=0 and busy_o=0.
REQ-029 SHALL apply REQ-027/028 on reset mid-operation, discarding in-flight entries; the first clock after release loads entry[0] normally.

Configuration
REQ-030 SHALL use macro PIPE_HAZARD_FWD_EN to select forwarding.
REQ-031 SHALL, with PIPE_HAZARD_FWD_EN defined, operate as REQ-018..026.
REQ-032 SHALL, without PIPE_HAZARD_FWD_EN, tie fwd*_sel_o to 0 and raise stall_o for any match at k<STAGES-1, relying on the write-through register file at STAGES-1.

Structure
REQ-033 SHALL declare in package pipe_pkg: entry typedef, FWD_RF=0 constant and the select-width function.
REQ-034 SHALL use a single sub-module pipe_match (youngest-match priority encoder returning hit, index and load), instantiated once per operand.

Verification (STAGES=3, LOAD_STAGE=1, macro defined)
REQ-035 SHALL cover ALU RAW: add x5, then consecutive readers of x5 -> fwd1_sel_o=1,2,3 then 0, with stall_o=0 throughout.
REQ-036 SHALL cover load-use: lw x6, then add rs2=x6 -> stall_o=1 for one cycle and entry[0] bubble, then fwd2_sel_o=2.
REQ-037 SHALL cover x0: rd=0 write, then reader rs1=0 -> fwd1_sel_o=0 and stall_o=0.
REQ-038 SHALL cover redirect during a pending load-use: ex_redirect_i=1 -> flush_o=1, stall_o=0, and entry[0] invalid next cycle.
REQ-039 SHALL cover a 3-cycle ext_stall_i: selects and busy_o stay constant and stall_o=1, and the sequence resumes unchanged afterwards.
REQ-040 SHALL cover async reset with 3 valid entries -> busy_o=0 and fwd*_sel_o=0 before the next clock edge; with the macro undefined, add x5 followed by a reader of x5 -> stall_o=1 for 2 cycles, then sel=0.
